// File: rtl/truth_table_sweep.sv
// truth_table_sweep: walks an N-bit vector through every minterm of a programmable
// table and checks an external combinational block against it, one minterm per clock.
// Latency: first valid vector one cycle after start; done pulses 2^N+1 cycles after start with no hold.
// Backpressure: hold stalls the sweep; vec and all results freeze while it is high.
module truth_table_sweep #(
  parameter int                N  = 2,
  parameter logic [(1<<N)-1:0] TT = 4'b1101
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                load,
  input  logic [(1<<N)-1:0]   tt_in,
  input  logic                hold,
  input  logic                dut_f,
  output logic [N-1:0]        vec,
  output logic                vec_valid,
  output logic                ref_f,
  output logic                busy,
  output logic                done,
  output logic [N:0]          ones_cnt,
  output logic [N:0]          err_cnt,
  output logic                err_flag,
  output logic [N-1:0]        first_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state_q;
  logic [(1<<N)-1:0]   tbl_q;
  logic [N-1:0]        vec_q;
  logic                busy_q;
  logic                done_q;
  logic [N:0]          ones_q;
  logic [N:0]          err_q;
  logic                err_flag_q;
  logic [N-1:0]        first_err_q;

  logic [N-1:0]        vec_d;
  logic [N:0]          ones_d;
  logic [N:0]          err_d;
  logic                sample;
  logic                mismatch;
  logic                last_vec;

  // Decode the per-cycle compare strobe and the incremented counter values.
  always_comb begin
    ref_f    = tbl_q[vec_q];
    sample   = (state_q == SWEEP) && !hold;
    mismatch = (dut_f != ref_f);
    last_vec = (vec_q == {N{1'b1}});
    vec_d    = vec_q + N'(1);
    ones_d   = ones_q + (N+1)'(1);
    err_d    = err_q + (N+1)'(1);
  end

  // Sweep controller: table load, minterm walk, result accumulation and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tbl_q       <= TT;
      vec_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ones_q      <= '0;
      err_q       <= '0;
      err_flag_q  <= 1'b0;
      first_err_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          // A simultaneous load lands in tbl_q on the same edge the sweep starts,
          // so the new table is already in place for minterm 0.
          if (load) begin
            tbl_q <= tt_in;
          end
          if (start) begin
            vec_q       <= '0;
            ones_q      <= '0;
            err_q       <= '0;
            err_flag_q  <= 1'b0;
            first_err_q <= '0;
            busy_q      <= 1'b1;
            state_q     <= SWEEP;
          end
        end
        SWEEP: begin
          if (sample) begin
            if (ref_f) begin
              ones_q <= ones_d;
            end
            if (mismatch) begin
              err_q      <= err_d;
              err_flag_q <= 1'b1;
              // Minterms are visited in ascending order, so the first miss is the lowest.
              if (!err_flag_q) begin
                first_err_q <= vec_q;
              end
            end
            // Stop on the last minterm instead of wrapping so vec stays in range.
            if (last_vec) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              vec_q <= vec_d;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign vec       = vec_q;
  assign vec_valid = sample;
  assign busy      = busy_q;
  assign done      = done_q;
  assign ones_cnt  = ones_q;
  assign err_cnt   = err_q;
  assign err_flag  = err_flag_q;
  assign first_err = first_err_q;

endmodule

// File: tb/tb_truth_table_sweep.sv
// Scoreboard bench for truth_table_sweep: stimulus pushes expected minterm/ref pairs
// and final results into queues; monitors pop and compare on vec_valid and done.
// Covers N=2 directed scenarios (good/bad DUT, load, hold, busy pokes, reset) and N=3.
module tb_truth_table_sweep;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // N=2 instance
  logic       start2, load2, hold2, dut_f2;
  logic [3:0] tt_in2;
  logic [1:0] vec2;
  logic       vec_valid2, ref_f2, busy2, done2, err_flag2;
  logic [2:0] ones2, err2;
  logic [1:0] first2;

  // N=3 instance
  logic       start3, load3, hold3, dut_f3;
  logic [7:0] tt_in3;
  logic [2:0] vec3;
  logic       vec_valid3, ref_f3, busy3, done3, err_flag3;
  logic [3:0] ones3, err3;
  logic [2:0] first3;

  truth_table_sweep #(.N(2), .TT(4'b1101)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .load(load2), .tt_in(tt_in2),
    .hold(hold2), .dut_f(dut_f2), .vec(vec2), .vec_valid(vec_valid2),
    .ref_f(ref_f2), .busy(busy2), .done(done2), .ones_cnt(ones2),
    .err_cnt(err2), .err_flag(err_flag2), .first_err(first2)
  );

  truth_table_sweep #(.N(3), .TT(8'hFF)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .load(load3), .tt_in(tt_in3),
    .hold(hold3), .dut_f(dut_f3), .vec(vec3), .vec_valid(vec_valid3),
    .ref_f(ref_f3), .busy(busy3), .done(done3), .ones_cnt(ones3),
    .err_cnt(err3), .err_flag(err_flag3), .first_err(first3)
  );

  // Implementation under test for N=2: mode 0 = NAND-only a + b', 1 = buggy a + b, 2 = tied 0.
  int   mode;
  logic ga, gb, na;
  always_comb begin
    ga = vec2[1];
    gb = vec2[0];
    na = ~(ga & ga);
    case (mode)
      0:       dut_f2 = ~(na & gb);
      1:       dut_f2 = ga | gb;
      default: dut_f2 = 1'b0;
    endcase
  end
  assign dut_f3 = 1'b1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] vec;
    logic       rf;
  } step_t;

  typedef struct {
    logic [8:0] ones;
    logic [8:0] err;
    logic       flag;
    logic [7:0] first;
  } fin_t;

  step_t step_q2[$];
  step_t step_q3[$];
  fin_t  fin_q2[$];
  fin_t  fin_q3[$];
  step_t s2, s3;
  fin_t  f2, f3;
  int    valid3_cnt = 0;

  // Monitor for the N=2 instance.
  always @(negedge clk) begin
    if (rst_n) begin
      if (vec_valid2) begin
        if (step_q2.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_valid2 actual=vec%0d expected=none", vec2);
        end else begin
          s2 = step_q2.pop_front();
          chk("vec2", vec2, s2.vec);
          chk("ref_f2", ref_f2, s2.rf);
        end
      end
      if (done2) begin
        if (fin_q2.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_done2 actual=1 expected=0");
        end else begin
          f2 = fin_q2.pop_front();
          chk("ones_cnt2", ones2, f2.ones);
          chk("err_cnt2", err2, f2.err);
          chk("err_flag2", err_flag2, f2.flag);
          chk("first_err2", first2, f2.first);
        end
      end
    end
  end

  // Monitor for the N=3 instance.
  always @(negedge clk) begin
    if (rst_n) begin
      if (vec_valid3) begin
        valid3_cnt++;
        if (step_q3.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_valid3 actual=vec%0d expected=none", vec3);
        end else begin
          s3 = step_q3.pop_front();
          chk("vec3", vec3, s3.vec);
          chk("ref_f3", ref_f3, s3.rf);
        end
      end
      if (done3) begin
        if (fin_q3.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_done3 actual=1 expected=0");
        end else begin
          f3 = fin_q3.pop_front();
          chk("ones_cnt3", ones3, f3.ones);
          chk("err_cnt3", err3, f3.err);
          chk("err_flag3", err_flag3, f3.flag);
          chk("first_err3", first3, f3.first);
        end
      end
    end
  end

  task automatic expect2(input logic [3:0] refs, input int ones, input int err,
                         input logic flag, input int first);
    step_t s;
    fin_t  f;
    for (int m = 0; m < 4; m++) begin
      s.vec = 8'(m);
      s.rf  = refs[m];
      step_q2.push_back(s);
    end
    f.ones  = 9'(ones);
    f.err   = 9'(err);
    f.flag  = flag;
    f.first = 8'(first);
    fin_q2.push_back(f);
  endtask

  // One full N=2 sweep; optional hold on the vec=1 cycles and start/load pokes while busy.
  task automatic sweep(input logic ld, input logic [3:0] tt, input int md,
                       input bit do_hold, input bit poke, input int exp_lat);
    int c;
    bit seen;
    mode   = md;
    load2  = ld;
    tt_in2 = tt;
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    load2  = 1'b0;
    tt_in2 = 4'b0000;
    chk("busy_after_start", busy2, 1);
    chk("vec_after_start", vec2, 0);
    c = 0;
    seen = 0;
    while (!seen && c < 30) begin
      hold2 = do_hold && (c == 1 || c == 2);
      if (do_hold && c >= 1 && c <= 3) chk("vec_held", vec2, 1);
      start2 = poke && (c == 1);
      load2  = poke && (c == 1);
      tt_in2 = (poke && c == 1) ? 4'b1111 : 4'b0000;
      @(posedge clk); #1;
      c++;
      if (done2) seen = 1;
    end
    hold2  = 1'b0;
    start2 = 1'b0;
    load2  = 1'b0;
    tt_in2 = 4'b0000;
    if (!seen) begin
      checks++; failures++;
      $display("FAIL done_timeout actual=%0d expected=%0d", c, exp_lat);
    end else begin
      chk("done_latency", c, exp_lat);
    end
    @(posedge clk); #1;
    chk("done_one_cycle", done2, 0);
    chk("idle_not_busy", busy2, 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_vec"}, vec2, 0);
    chk({tag, "_vec_valid"}, vec_valid2, 0);
    chk({tag, "_ref_f"}, ref_f2, 1);
    chk({tag, "_busy"}, busy2, 0);
    chk({tag, "_done"}, done2, 0);
    chk({tag, "_ones"}, ones2, 0);
    chk({tag, "_err"}, err2, 0);
    chk({tag, "_flag"}, err_flag2, 0);
    chk({tag, "_first"}, first2, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step_t s;
    fin_t  f;
    int    c;
    rst_n  = 1'b0;
    mode   = 0;
    start2 = 1'b0; load2 = 1'b0; hold2 = 1'b0; tt_in2 = 4'b0000;
    start3 = 1'b0; load3 = 1'b0; hold3 = 1'b0; tt_in3 = 8'h00;
    #12;
    chk_reset_vals("por");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Correct NAND-only a + b'
    expect2(4'b1101, 3, 0, 1'b0, 0);
    sweep(1'b0, 4'b0000, 0, 1'b0, 1'b0, 4);

    // Buggy a + b: misses at m0 and m1
    expect2(4'b1101, 3, 2, 1'b1, 0);
    sweep(1'b0, 4'b0000, 1, 1'b0, 1'b0, 4);

    // Hold for two cycles at vec=1: done two cycles later, same results
    expect2(4'b1101, 3, 0, 1'b0, 0);
    sweep(1'b0, 4'b0000, 0, 1'b1, 1'b0, 6);

    // Load 0001 together with start, DUT tied low
    expect2(4'b0001, 1, 1, 1'b1, 0);
    sweep(1'b1, 4'b0001, 2, 1'b0, 1'b0, 4);

    // start/load poked while busy (load of 1111) must be ignored
    expect2(4'b0001, 1, 1, 1'b1, 0);
    sweep(1'b0, 4'b0000, 2, 1'b0, 1'b1, 4);

    // Reset mid-sweep at vec=2 with table 0001 loaded
    for (int m = 0; m < 2; m++) begin
      s.vec = 8'(m);
      s.rf  = (m == 0);
      step_q2.push_back(s);
    end
    mode   = 0;
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("vec_before_reset", vec2, 2);
    chk("ones_before_reset", ones2, 1);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    @(posedge clk); #1;
    chk("no_done_in_reset", done2, 0);
    rst_n = 1'b1;
    chk("steps_drained", step_q2.size(), 0);
    chk("no_final_pending", fin_q2.size(), 0);
    @(posedge clk); #1;
    // Table back to 1101 after reset
    expect2(4'b1101, 3, 0, 1'b0, 0);
    sweep(1'b0, 4'b0000, 0, 1'b0, 1'b0, 4);

    // N=3, all-ones table
    for (int m = 0; m < 8; m++) begin
      s.vec = 8'(m);
      s.rf  = 1'b1;
      step_q3.push_back(s);
    end
    f.ones = 9'd8; f.err = 9'd0; f.flag = 1'b0; f.first = 8'd0;
    fin_q3.push_back(f);
    valid3_cnt = 0;
    start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    c = 0;
    while (!done3 && c < 40) begin
      @(posedge clk); #1;
      c++;
    end
    if (!done3) begin
      checks++; failures++;
      $display("FAIL done3_timeout actual=%0d expected=8", c);
    end else begin
      chk("done3_latency", c, 8);
    end
    @(posedge clk); #1;
    chk("valid3_count", valid3_cnt, 8);
    chk("done3_one_cycle", done3, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("q2_steps_empty", step_q2.size(), 0);
    chk("q2_final_empty", fin_q2.size(), 0);
    chk("q3_steps_empty", step_q3.size(), 0);
    chk("q3_final_empty", fin_q3.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
